vtree_request_filler: RTL and testbench

Request-driven record supplier that sits between the upstream record loaders and the root input of the virtual sorter stage tree. It accepts way-index requests from the tree, queues them in order, and returns the head record of the requested way from per-way record buffers together with its way index. Beyond a plain request-queue front end, it provides per-way buffering with refill status, and in-order stall when a requested way is dry. It also emits an all-ones sentinel for exhausted ways so the tree drains cleanly at end of data.

---
 rtl/vtree_request_filler.sv | 192 +++++++++++++++++++
 tb/tb_vtree_request_filler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtree_request_filler.sv
// vtree_request_filler
//
// Supplies records to the root input of the virtual sorter stage tree.
// The tree names a way it wants through a request. Requests are queued
// and served strictly in order. Each request returns the oldest buffered
// record of that way together with the way index. When a way is finished
// upstream and its buffer is empty, the request returns an all-ones
// sentinel instead, so the tree can drain at end of data.
//
// Ports:
//   CLK, RST         clock; asynchronous active-high reset
//   i_request        way index requested by the tree
//   i_request_valid  request strobe
//   queue_full       request queue is at full depth
//   din              record from the upstream loader
//   dinen            record write strobe
//   din_idx          destination way of din
//   way_done         level, bit i = way i has no further records upstream
//   dot              record returned to the tree (registered)
//   doten            one-cycle pulse, dot is valid
//   dot_idx          way index of dot
//   emp              bit i = way i buffer is empty
//   ful              bit i = way i buffer is full
//   err              sticky flag: a request or a record was dropped
module vtree_request_filler #(
    parameter int W_LOG     = 7,
    parameter int Q_SIZE    = 2,
    parameter int FIFO_SIZE = 2,
    parameter int DATW      = 64,
    parameter int KEYW      = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [W_LOG-1:0]        i_request,
    input  logic                    i_request_valid,
    output logic                    queue_full,
    input  logic [DATW-1:0]         din,
    input  logic                    dinen,
    input  logic [W_LOG-1:0]        din_idx,
    input  logic [(1<<W_LOG)-1:0]   way_done,
    output logic [DATW-1:0]         dot,
    output logic                    doten,
    output logic [W_LOG-1:0]        dot_idx,
    output logic [(1<<W_LOG)-1:0]   emp,
    output logic [(1<<W_LOG)-1:0]   ful,
    output logic                    err
);

    localparam int WAYS   = 1 << W_LOG;
    localparam int QDEPTH = 1 << Q_SIZE;
    localparam int FDEPTH = 1 << FIFO_SIZE;
    localparam int QCW    = Q_SIZE + 1;
    localparam int FCW    = FIFO_SIZE + 1;
    localparam logic [QCW-1:0] QUEUE_FULL_CNT = QCW'(QDEPTH);
    localparam logic [FCW-1:0] WAY_FULL_CNT   = FCW'(FDEPTH);

    // Keys live in the low KEYW bits of a record, so they cannot be wider.
    if (KEYW > DATW) begin : gKeyWidthCheck
        $error("KEYW must not exceed DATW");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_WAIT
    } FillState;

    logic [W_LOG-1:0]     reqMemQ   [QDEPTH];
    logic [Q_SIZE-1:0]    reqHeadQ;
    logic [Q_SIZE-1:0]    reqTailQ;
    logic [QCW-1:0]       reqCountQ;

    logic [DATW-1:0]      ramQ      [WAYS*FDEPTH];
    logic [FIFO_SIZE-1:0] wayHeadQ  [WAYS];
    logic [FIFO_SIZE-1:0] wayTailQ  [WAYS];
    logic [FCW-1:0]       wayCountQ [WAYS];
    logic                 errQ;

    FillState             stateNow;
    logic [W_LOG-1:0]     headWay;
    logic                 headHasData;
    logic                 serve;
    logic                 readRam;
    logic                 push;
    logic                 wrEn;
    logic                 errEvent;
    logic [DATW-1:0]      dotD;

    assign queue_full = (reqCountQ == QUEUE_FULL_CNT);
    assign err        = errQ;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            emp[w] = (wayCountQ[w] == '0);
            ful[w] = (wayCountQ[w] == WAY_FULL_CNT);
        end
    end

    // The serve decision is taken from the queue head in the same cycle,
    // so a request sampled at one edge can be answered at the next edge.
    // A head that is not serviceable blocks everything queued behind it.
    always_comb begin
        headWay     = reqMemQ[reqHeadQ];
        headHasData = (wayCountQ[headWay] != '0);
        if (reqCountQ == '0) begin
            stateNow = ST_IDLE;
        end else if (headHasData || way_done[headWay]) begin
            stateNow = ST_SERVE;
        end else begin
            stateNow = ST_WAIT;
        end
        serve   = (stateNow == ST_SERVE);
        readRam = serve && headHasData;

        // Fullness is judged before this cycle's pop. A pop in the same
        // cycle frees the slot, so the incoming request or record still
        // fits. A full way being read this cycle can therefore take the
        // write: it lands in the slot being vacated, because the tail
        // equals the head when the buffer is full.
        push     = i_request_valid && (!queue_full || serve);
        wrEn     = dinen && (!ful[din_idx] || (readRam && (din_idx == headWay)));
        errEvent = (i_request_valid && !push) || (dinen && !wrEn);

        dotD = readRam ? ramQ[{headWay, wayHeadQ[headWay]}] : {DATW{1'b1}};
    end

    // The record store holds data only, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (wrEn) begin
            ramQ[{din_idx, wayTailQ[din_idx]}] <= din;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reqHeadQ  <= '0;
            reqTailQ  <= '0;
            reqCountQ <= '0;
            for (int q = 0; q < QDEPTH; q++) begin
                reqMemQ[q] <= '0;
            end
            for (int w = 0; w < WAYS; w++) begin
                wayHeadQ[w]  <= '0;
                wayTailQ[w]  <= '0;
                wayCountQ[w] <= '0;
            end
            dot     <= '0;
            doten   <= 1'b0;
            dot_idx <= '0;
            errQ    <= 1'b0;
        end else begin
            if (push) begin
                reqMemQ[reqTailQ] <= i_request;
                reqTailQ          <= reqTailQ + 1'b1;
            end
            if (serve) begin
                reqHeadQ <= reqHeadQ + 1'b1;
            end
            if (push && !serve) begin
                reqCountQ <= reqCountQ + 1'b1;
            end else if (!push && serve) begin
                reqCountQ <= reqCountQ - 1'b1;
            end

            // If a way is written and read in the same cycle, both of its
            // pointers advance and its count stays the same.
            if (wrEn) begin
                wayTailQ[din_idx] <= wayTailQ[din_idx] + 1'b1;
            end
            if (readRam) begin
                wayHeadQ[headWay] <= wayHeadQ[headWay] + 1'b1;
            end
            if (wrEn && !(readRam && (din_idx == headWay))) begin
                wayCountQ[din_idx] <= wayCountQ[din_idx] + 1'b1;
            end
            if (readRam && !(wrEn && (din_idx == headWay))) begin
                wayCountQ[headWay] <= wayCountQ[headWay] - 1'b1;
            end

            doten <= serve;
            if (serve) begin
                dot     <= dotD;
                dot_idx <= headWay;
            end

            if (errEvent) begin
                errQ <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vtree_request_filler.sv
// Testbench for vtree_request_filler with eight ways, queue depth 4 and
// per-way buffer depth 4. A reference model keeps the pending requests
// and the buffered records of each way as plain queues. Every cycle it
// derives the expected outputs from the record-supply rules.
module tb_vtree_request_filler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  i_request = '0;
    logic        i_request_valid = 1'b0;
    logic        queue_full;
    logic [63:0] din = '0;
    logic        dinen = 1'b0;
    logic [2:0]  din_idx = '0;
    logic [7:0]  way_done = '0;
    logic [63:0] dot;
    logic        doten;
    logic [2:0]  dot_idx;
    logic [7:0]  emp;
    logic [7:0]  ful;
    logic        err;

    vtree_request_filler #(
        .W_LOG(3), .Q_SIZE(2), .FIFO_SIZE(2), .DATW(64), .KEYW(32)
    ) dut (
        .CLK(CLK), .RST(RST),
        .i_request(i_request), .i_request_valid(i_request_valid),
        .queue_full(queue_full),
        .din(din), .dinen(dinen), .din_idx(din_idx),
        .way_done(way_done),
        .dot(dot), .doten(doten), .dot_idx(dot_idx),
        .emp(emp), .ful(ful), .err(err)
    );

    always #5 CLK = ~CLK;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state.
    int          mReq[$];
    logic [63:0] mWay[8][$];
    logic        mErr;
    logic [7:0]  doneLvl = '0;

    // Records returned by the DUT, for whole-sequence checks.
    logic [63:0] gotDot[$];
    int          gotIdx[$];
    int          dotenSeen;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic void resetModel();
        mReq.delete();
        for (int w = 0; w < 8; w++) mWay[w].delete();
        mErr = 1'b0;
    endfunction

    function automatic void clearLog();
        gotDot.delete();
        gotIdx.delete();
        dotenSeen = 0;
    endfunction

    // One clock cycle: drive the inputs, predict the result with the model,
    // clock the DUT and compare.
    task automatic applyStimulus(input logic rv, input logic [2:0] rq,
                                 input logic we, input logic [2:0] wi,
                                 input logic [63:0] wd);
        logic        served;
        logic        servedData;
        logic        qFullBefore;
        int          h;
        logic [63:0] outData;
        logic [7:0]  expEmp;
        logic [7:0]  expFul;
        @(negedge CLK);
        i_request_valid = rv;
        i_request       = rq;
        dinen           = we;
        din_idx         = wi;
        din             = wd;
        way_done        = doneLvl;

        served      = 1'b0;
        servedData  = 1'b0;
        h           = 0;
        outData     = '1;
        qFullBefore = (mReq.size() == 4);
        if (mReq.size() > 0) begin
            h = mReq[0];
            if (mWay[h].size() > 0) begin
                served     = 1'b1;
                servedData = 1'b1;
                outData    = mWay[h][0];
            end else if (doneLvl[h]) begin
                served = 1'b1;
            end
        end
        if (we) begin
            if (mWay[wi].size() < 4 || (servedData && h == int'(wi)))
                mWay[wi].push_back(wd);
            else
                mErr = 1'b1;
        end
        if (servedData) void'(mWay[h].pop_front());
        if (served) void'(mReq.pop_front());
        if (rv) begin
            if (!qFullBefore || served) mReq.push_back(int'(rq));
            else mErr = 1'b1;
        end
        for (int w = 0; w < 8; w++) begin
            expEmp[w] = (mWay[w].size() == 0);
            expFul[w] = (mWay[w].size() == 4);
        end

        @(posedge CLK);
        #1;
        checkOutput("doten", doten, served);
        if (served) begin
            checkOutput("dot", dot, outData);
            checkOutput("dot_idx", dot_idx, h[2:0]);
        end
        checkOutput("queue_full", queue_full, mReq.size() == 4);
        checkOutput("emp", emp, expEmp);
        checkOutput("ful", ful, expFul);
        checkOutput("err", err, mErr);
        if (doten === 1'b1) begin
            gotDot.push_back(dot);
            gotIdx.push_back(int'(dot_idx));
            dotenSeen++;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic resetDut();
        @(negedge CLK);
        RST = 1'b1;
        i_request_valid = 1'b0;
        dinen = 1'b0;
        doneLvl = '0;
        way_done = '0;
        #2;
        checkOutput("rst_doten", doten, 1'b0);
        checkOutput("rst_emp", emp, 8'hFF);
        checkOutput("rst_err", err, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        resetModel();
        clearLog();
    endtask

    initial begin
        resetModel();
        clearLog();
        #12;
        checkOutput("rst_dot", dot, 64'h0);
        checkOutput("rst_dot_idx", dot_idx, 3'd0);
        checkOutput("rst_queue_full", queue_full, 1'b0);
        checkOutput("rst_ful", ful, 8'h00);
        resetDut();

        // Two records per way, keys way+1 then way+9, served in request order.
        for (int r = 0; r < 2; r++)
            for (int w = 0; w < 8; w++)
                applyStimulus(1'b0, '0, 1'b1, w[2:0], 64'(w + 1 + 8 * r));
        for (int r = 0; r < 2; r++)
            for (int w = 0; w < 8; w++)
                applyStimulus(1'b1, w[2:0], 1'b0, '0, '0);
        idleCycles(3);
        checkOutput("t1_count", gotDot.size(), 16);
        for (int i = 0; i < 16 && i < gotDot.size(); i++) begin
            checkOutput("t1_key", gotDot[i], 64'(i + 1));
            checkOutput("t1_idx", gotIdx[i], i % 8);
        end
        checkOutput("t1_emp", emp, 8'hFF);

        // Stall on an empty way; the request behind it must not overtake.
        clearLog();
        applyStimulus(1'b1, 3'd5, 1'b0, '0, '0);
        applyStimulus(1'b1, 3'd2, 1'b0, '0, '0);
        idleCycles(2);
        applyStimulus(1'b0, '0, 1'b1, 3'd2, 64'd77);
        applyStimulus(1'b0, '0, 1'b1, 3'd5, 64'd42);
        idleCycles(3);
        checkOutput("t2_count", gotDot.size(), 2);
        if (gotDot.size() == 2) begin
            checkOutput("t2_first_key", gotDot[0], 64'd42);
            checkOutput("t2_first_idx", gotIdx[0], 5);
            checkOutput("t2_second_key", gotDot[1], 64'd77);
        end

        // Real records before the sentinel on a finished way.
        clearLog();
        applyStimulus(1'b0, '0, 1'b1, 3'd3, 64'd7);
        doneLvl = 8'h08;
        applyStimulus(1'b1, 3'd3, 1'b0, '0, '0);
        applyStimulus(1'b1, 3'd3, 1'b0, '0, '0);
        idleCycles(3);
        checkOutput("t3_count", gotDot.size(), 2);
        if (gotDot.size() == 2) begin
            checkOutput("t3_key", gotDot[0], 64'd7);
            checkOutput("t3_sentinel", gotDot[1], 64'hFFFF_FFFF_FFFF_FFFF);
            checkOutput("t3_sentinel_idx", gotIdx[1], 3);
        end

        // Overfull request queue drops the extra request.
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd6, 1'b0, '0, '0);
        checkOutput("t4_queue_full", queue_full, 1'b1);
        applyStimulus(1'b1, 3'd6, 1'b0, '0, '0);
        checkOutput("t4_err", err, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 3'd6, 64'(100 + i));
        idleCycles(8);
        checkOutput("t4_pulses", dotenSeen, 4);

        // Overfull way buffer, then a write while that way is being read.
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 3'd1, 64'(200 + i));
            if (i == 3) checkOutput("t5_ful_after4", ful[1], 1'b1);
        end
        checkOutput("t5_err", err, 1'b1);
        applyStimulus(1'b1, 3'd1, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b1, 3'd1, 64'd300);
        checkOutput("t5_ful_kept", ful[1], 1'b1);
        idleCycles(2);

        // Asynchronous reset while a record is being delivered.
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 3'd0, 64'(50 + i));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd0, 1'b0, '0, '0);
        checkOutput("t6_doten_before", doten, 1'b1);
        #1 RST = 1'b1;
        #1;
        checkOutput("t6_doten", doten, 1'b0);
        checkOutput("t6_dot", dot, 64'h0);
        checkOutput("t6_emp", emp, 8'hFF);
        checkOutput("t6_queue_full", queue_full, 1'b0);
        i_request_valid = 1'b0;
        dinen = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        resetModel();
        clearLog();

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) doneLvl = 8'($urandom & $urandom & $urandom);
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
